// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache-side types: line/burst containers, adaptor FSM states and beat count.
package cache_types;

  localparam int CACHELINE_BITS = 256;
  localparam int BURST_BITS     = 64;
  localparam int BEATS          = CACHELINE_BITS / BURST_BITS;

  typedef logic [CACHELINE_BITS-1:0] cacheline_t;
  typedef logic [BURST_BITS-1:0]     burst_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  // True when n is a positive power of two.
  function automatic logic is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one full-line cache read/write into a BEATS-long
// burst on the physical memory port. One transaction in flight at a time.
module cacheline_adaptor
  import cache_types::*;
#(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  // cache side
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  // pmem side
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   resp_i
);

  localparam int NUM_BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int LINE_BYTES = LINE_WIDTH / 8;

  // Clearing the low address bits gives the line-aligned pmem address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(NUM_BEATS - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

  // The counter wraps naturally only when the beat count is a power of two.
  if (!is_pow2(NUM_BEATS) || (NUM_BEATS < 2) ||
      (NUM_BEATS * BURST_WIDTH != LINE_WIDTH)) begin : g_bad_geometry
    $error("cacheline_adaptor: LINE_WIDTH/BURST_WIDTH must be a power of two >= 2");
  end

  adaptor_state_t          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  // State, beat counter, line buffer and address register; reset clears all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic: capture request in IDLE, count beats on resp_i, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        // write has priority over read when both are presented
        if (write_i) begin
          line_d  = line_i;
          addr_d  = address_i & ALIGN_MASK;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = address_i & ALIGN_MASK;
          cnt_d   = '0;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        // requests are deliberately not sampled here so a held request cannot restart
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state so reset clears them without a clock.
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = ((state_q == READ) || (state_q == WRITE)) ? addr_q : '0;
  assign burst_o   = (state_q == WRITE) ? line_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] : '0;
  assign line_o    = line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed table, hand-written
// multi-cycle sequences and random traffic against a transaction-level model.
module tb_cacheline_adaptor;

  localparam int NB = 4;   // beats per line

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  address_i = 32'h0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [255:0] line_i = 256'h0;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i = 64'h0;
  logic         resp_i = 1'b0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is "open" from acceptance until NB beats have moved,
  // then completion is reported for one cycle.
  logic        m_open, m_is_wr, m_done;
  int          m_beats;
  logic [31:0] m_addr;
  logic [63:0] m_words [NB];

  task automatic model_reset();
    m_open = 1'b0; m_is_wr = 1'b0; m_done = 1'b0; m_beats = 0; m_addr = 32'h0;
    for (int i = 0; i < NB; i++) m_words[i] = 64'h0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_open) begin
      if (resp_i) begin
        if (!m_is_wr) m_words[m_beats] = burst_i;
        m_beats++;
        if (m_beats == NB) begin
          m_open = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (write_i || read_i) begin
      m_open  = 1'b1;
      m_is_wr = write_i;
      m_beats = 0;
      m_addr  = (address_i / 32) * 32;
      if (write_i) for (int i = 0; i < NB; i++) m_words[i] = line_i[64*i +: 64];
    end
  endtask

  task automatic model_compare();
    logic [63:0]  eb;
    logic [255:0] el;
    eb = 64'h0;
    if (m_open && m_is_wr) eb = m_words[m_beats];
    el = {m_words[3], m_words[2], m_words[1], m_words[0]};
    chk("model_read_o",    read_o,    m_open && !m_is_wr);
    chk("model_write_o",   write_o,   m_open && m_is_wr);
    chk("model_resp_o",    resp_o,    m_done);
    chk("model_address_o", address_o, m_open ? m_addr : 32'h0);
    chk("model_burst_o",   burst_o,   eb);
    chk("model_line_o",    line_o,    el);
  endtask

  // One clock: advance the model with the inputs seen at this edge, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_compare();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         rd, wr, rsp;
    logic [31:0]  addr;
    logic [63:0]  bi;
    logic         e_rd, e_wr, e_rsp;
    logic [31:0]  e_addr;
    logic [255:0] e_line;
  } vec_t;

  localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] Z  = 64'h0;

  vec_t vt [7];

  logic [63:0]  w2 [NB];
  logic [63:0]  rw [NB];
  bit           pat [7];
  int           cnt_a, cnt_b;

  initial begin
    // --- reset state, checked before any clock edge ---
    #2 rst = 1'b1;
    #1;
    chk("rst_read_o",  read_o,    1'b0);
    chk("rst_write_o", write_o,   1'b0);
    chk("rst_resp_o",  resp_o,    1'b0);
    chk("rst_addr_o",  address_o, 32'h0);
    chk("rst_burst_o", burst_o,   64'h0);
    chk("rst_line_o",  line_o,    256'h0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;   // released away from the clock edge

    // --- table: back-to-back read, then idle resp_i noise ---
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, Z,  1'b1, 1'b0, 1'b0, 32'h0000_1220, {Z, Z, Z, Z}};
    vt[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_1234, W1, 1'b1, 1'b0, 1'b0, 32'h0000_1220, {Z, Z, Z, W1}};
    vt[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_1234, W2, 1'b1, 1'b0, 1'b0, 32'h0000_1220, {Z, Z, W2, W1}};
    vt[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_1234, W3, 1'b1, 1'b0, 1'b0, 32'h0000_1220, {Z, W3, W2, W1}};
    vt[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_1234, W4, 1'b0, 1'b0, 1'b1, 32'h0,         {W4, W3, W2, W1}};
    vt[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_1234, Z,  1'b0, 1'b0, 1'b0, 32'h0,         {W4, W3, W2, W1}};
    vt[6] = '{1'b0, 1'b0, 1'b1, 32'h0000_5678, 64'hDEAD_BEEF_0BAD_F00D,
              1'b0, 1'b0, 1'b0, 32'h0,         {W4, W3, W2, W1}};
    for (int i = 0; i < 7; i++) begin
      read_i = vt[i].rd; write_i = vt[i].wr; resp_i = vt[i].rsp;
      address_i = vt[i].addr; burst_i = vt[i].bi;
      tick();
      chk($sformatf("vec%0d_read_o", i),  read_o,    vt[i].e_rd);
      chk($sformatf("vec%0d_write_o", i), write_o,   vt[i].e_wr);
      chk($sformatf("vec%0d_resp_o", i),  resp_o,    vt[i].e_rsp);
      chk($sformatf("vec%0d_addr_o", i),  address_o, vt[i].e_addr);
      chk($sformatf("vec%0d_burst_o", i), burst_o,   64'h0);
      chk($sformatf("vec%0d_line_o", i),  line_o,    vt[i].e_line);
    end
    resp_i = 1'b0;

    // --- write with stalled beats: resp_i = 1,0,0,1,1,0,1 ---
    w2[3] = 64'h0123_4567_89AB_CDEF; w2[2] = 64'hFEDC_BA98_7654_3210;
    w2[1] = 64'h0F1E_2D3C_4B5A_6978; w2[0] = 64'h8796_A5B4_C3D2_E1F0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    line_i = {w2[3], w2[2], w2[1], w2[0]};
    address_i = 32'h0000_8ABC; write_i = 1'b1;
    tick();
    chk("wr_start_write_o", write_o,   1'b1);
    chk("wr_addr_o",        address_o, 32'h0000_8AA0);
    chk("wr_beat0",         burst_o,   w2[0]);
    write_i = 1'b0; line_i = {4{64'hFFFF_FFFF_FFFF_FFFF}}; address_i = 32'hFFFF_FFFF;
    cnt_a = 1; cnt_b = 0;
    for (int k = 0; k < 7; k++) begin
      resp_i = pat[k];
      tick();
      if (pat[k]) cnt_b++;
      if (write_o) cnt_a++;
      if (k < 6) chk($sformatf("wr_burst_k%0d", k), burst_o, w2[cnt_b]);
    end
    chk("wr_write_o_cycles", cnt_a,   7);
    chk("wr_resp_o",         resp_o,  1'b1);
    chk("wr_done_write_o",   write_o, 1'b0);
    resp_i = 1'b0;
    tick();
    chk("wr_resp_pulse_end", resp_o, 1'b0);

    // --- read and write together: write wins ---
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0040;
    line_i = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    tick();
    chk("both_write_o", write_o, 1'b1);
    cnt_a = read_o ? 1 : 0;
    resp_i = 1'b1;
    for (int k = 0; k < NB; k++) begin
      tick();
      if (read_o) cnt_a++;
    end
    chk("both_read_o_never", cnt_a,  0);
    chk("both_resp_o",       resp_o, 1'b1);
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    tick();

    // --- request held through completion ---
    read_i = 1'b1; address_i = 32'h0000_4F7F;
    tick();
    cnt_a = 0;
    resp_i = 1'b1;
    for (int k = 0; k < NB; k++) begin
      burst_i = {$urandom(), $urandom()};
      tick();
      if (resp_o) cnt_a++;
    end
    resp_i = 1'b0;
    tick();
    if (resp_o) cnt_a++;
    tick();
    if (resp_o) cnt_a++;
    read_i = 1'b0;
    chk("hold_resp_pulses",  cnt_a,     1);
    chk("hold_restart_read", read_o,    1'b1);
    chk("hold_restart_addr", address_o, 32'h0000_4F60);
    resp_i = 1'b1;
    for (int k = 0; k < NB; k++) begin
      burst_i = {$urandom(), $urandom()};
      tick();
    end
    chk("hold_second_resp", resp_o, 1'b1);
    resp_i = 1'b0;
    tick();
    tick();
    chk("hold_no_third_txn", read_o, 1'b0);

    // --- reset in the middle of a read ---
    read_i = 1'b1; address_i = 32'h0000_2000;
    tick();
    resp_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      burst_i = {$urandom(), $urandom()};
      tick();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_read_o", read_o,    1'b0);
    chk("midrst_resp_o", resp_o,    1'b0);
    chk("midrst_line_o", line_o,    256'h0);
    chk("midrst_addr_o", address_o, 32'h0);
    resp_i = 1'b0; read_i = 1'b0;
    tick();
    rst = 1'b0;
    read_i = 1'b1; address_i = 32'h0000_3004;
    tick();
    chk("postrst_read_o", read_o, 1'b1);
    read_i = 1'b0; resp_i = 1'b1;
    for (int k = 0; k < NB; k++) begin
      rw[k] = {$urandom(), $urandom()};
      burst_i = rw[k];
      tick();
    end
    chk("postrst_resp_o", resp_o, 1'b1);
    chk("postrst_line_o", line_o, {rw[3], rw[2], rw[1], rw[0]});
    resp_i = 1'b0;
    tick();

    // --- random traffic against the model ---
    for (int c = 0; c < 600; c++) begin
      read_i    = ($urandom_range(0, 3) == 0);
      write_i   = ($urandom_range(0, 4) == 0);
      resp_i    = $urandom_range(0, 1) != 0;
      address_i = $urandom();
      burst_i   = {$urandom(), $urandom()};
      line_i    = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      if (read_o && write_o) chk("rand_rd_wr_exclusive", {read_o, write_o}, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
